// File: rtl/dac_spi_regfile_pkg.sv
// Shared types and field layout for the SPI-accessible DAC register file.
package dac_spi_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INSTR   = 2'd1,
    ST_DATA    = 2'd2,
    ST_OVERRUN = 2'd3
  } state_t;

  localparam int RW_BIT    = 7;
  localparam int N_MSB     = 6;
  localparam int N_LSB     = 5;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int REG_COUNT = 32;

  localparam logic [DATA_W-1:0] REG_RESET = 8'h00;

  typedef struct packed {
    logic                  rw;
    logic [N_MSB-N_LSB:0]  n;
    logic [ADDR_W-1:0]     addr;
  } instr_t;

  // Next register address inside a burst; wraps naturally at REG_COUNT.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/dac_spi_regfile_spi_in_sync.sv
// Brings the SPI pins into the clk domain and flags sclk/csb edges.
module spi_in_sync
  import dac_spi_regfile_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_csb,
  input  logic spi_sdi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csb_rise,
  output logic csb_fall,
  output logic csb_lvl,
  output logic sdi_lvl
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] csb_q;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic                   sclk_d;
  logic                   csb_d;

  // Presets make an idle bus (csb high, sclk low) look quiet out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      csb_q  <= '1;
      sdi_q  <= '0;
      sclk_d <= 1'b0;
      csb_d  <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      csb_q  <= {csb_q[SYNC_STAGES-2:0], spi_csb};
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], spi_sdi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      csb_d  <= csb_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign csb_rise  = csb_q[SYNC_STAGES-1] & ~csb_d;
  assign csb_fall  = ~csb_q[SYNC_STAGES-1] & csb_d;
  assign csb_lvl   = csb_q[SYNC_STAGES-1];
  assign sdi_lvl   = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/dac_spi_regfile.sv
// SPI slave register file: 32 x 8-bit registers, burst read/write over SPI,
// write notification and registered read port on the FPGA side.
module dac_spi_regfile
  import dac_spi_regfile_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic              frame_abort
);

  logic sclk_rise;
  logic sclk_fall;
  logic csb_rise;
  logic csb_fall;
  logic csb_lvl;
  logic sdi_lvl;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_sclk (spi_sclk),
    .spi_csb  (spi_csb),
    .spi_sdi  (spi_sdi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .csb_rise (csb_rise),
    .csb_fall (csb_fall),
    .csb_lvl  (csb_lvl),
    .sdi_lvl  (sdi_lvl)
  );

  state_t              state;
  state_t              next_state;
  logic [2:0]          bit_cnt;
  logic [DATA_W-1:0]   rx_sh;
  logic [DATA_W-1:0]   tx_sh;
  logic [1:0]          n_bytes;
  logic [1:0]          byte_idx;
  logic [ADDR_W-1:0]   addr;
  logic                rd_mode;
  logic [DATA_W-1:0]   regs [REG_COUNT];

  logic                bit_in;
  logic                byte_end;
  logic [DATA_W-1:0]   rx_byte;
  instr_t              instr;
  logic                wr_now;
  logic [ADDR_W-1:0]   addr_nxt;

  // Event decode from the synchronized bus
  always_comb begin
    bit_in   = sclk_rise && !csb_lvl && (state == ST_INSTR || state == ST_DATA);
    byte_end = bit_in && (bit_cnt == 3'd7);
    rx_byte  = {rx_sh[DATA_W-2:0], sdi_lvl};
    instr    = instr_t'(rx_byte);
    wr_now   = byte_end && (state == ST_DATA) && !rd_mode;
    addr_nxt = next_addr(addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A csb rise always wins; a csb fall in any state restarts the frame.
  always_comb begin
    next_state = state;
    if (csb_rise) begin
      next_state = ST_IDLE;
    end else if (csb_fall) begin
      next_state = ST_INSTR;
    end else if (byte_end) begin
      if (state == ST_INSTR) begin
        next_state = ST_DATA;
      end else if (state == ST_DATA && byte_idx == n_bytes) begin
        next_state = ST_OVERRUN;
      end
    end
  end

  // Shift, address sequencing and pin/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= 3'd0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      n_bytes     <= 2'd0;
      byte_idx    <= 2'd0;
      addr        <= '0;
      rd_mode     <= 1'b0;
      spi_sdo     <= 1'b1;
      spi_sdo_oe  <= 1'b0;
      reg_wr      <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      reg_wr      <= wr_now;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (wr_now) begin
        reg_waddr <= addr;
        reg_wdata <= rx_byte;
      end
      if (csb_rise) begin
        bit_cnt     <= 3'd0;
        spi_sdo     <= 1'b1;
        spi_sdo_oe  <= 1'b0;
        frame_done  <= (state == ST_OVERRUN);
        frame_abort <= (state == ST_INSTR) || (state == ST_DATA);
      end else if (csb_fall) begin
        bit_cnt    <= 3'd0;
        rx_sh      <= '0;
        spi_sdo    <= 1'b1;
        spi_sdo_oe <= 1'b0;
      end else begin
        if (bit_in) begin
          rx_sh   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_end && state == ST_INSTR) begin
          rd_mode  <= instr.rw;
          n_bytes  <= instr.n;
          addr     <= instr.addr;
          byte_idx <= 2'd0;
          tx_sh    <= regs[instr.addr];
        end else if (byte_end && state == ST_DATA) begin
          addr     <= addr_nxt;
          byte_idx <= byte_idx + 2'd1;
          tx_sh    <= regs[addr_nxt];
        end
        if (sclk_fall && !csb_lvl) begin
          if (state == ST_DATA && rd_mode) begin
            spi_sdo    <= tx_sh[DATA_W-1];
            tx_sh      <= {tx_sh[DATA_W-2:0], 1'b1};
            spi_sdo_oe <= 1'b1;
          end else if (state == ST_OVERRUN) begin
            spi_sdo    <= 1'b1;
            spi_sdo_oe <= 1'b0;
          end
        end
      end
    end
  end

  // Register array and FPGA read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= REG_RESET;
      end
    end else if (wr_now) begin
      regs[addr] <= rx_byte;
    end
  end

  // Same-cycle SPI write to the read address is forwarded so rd_data never
  // shows the stale value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= REG_RESET;
    end else if (wr_now && addr == rd_addr) begin
      rd_data <= rx_byte;
    end else begin
      rd_data <= regs[rd_addr];
    end
  end

endmodule

// File: doc/dac_spi_regfile.md
DAC_SPI_REGFILE -- requirements
Module: dac_spi_regfile

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on spi_sclk, spi_csb and spi_sdi (legal range 2..3).
REQ-002 SHALL have ports clk, rst, spi_sclk, spi_csb, spi_sdi, spi_sdo, spi_sdo_oe, reg_wr, reg_waddr, reg_wdata, rd_addr, rd_data, frame_done, frame_abort.
REQ-003 Port clk: input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous, active-high reset.
REQ-005 Ports spi_sclk, spi_csb (active low) and spi_sdi: inputs, 1 bit each, asynchronous to clk.
REQ-006 Port spi_sdo: output, 1 bit, read data. Port spi_sdo_oe: output, 1 bit, output enable for spi_sdo.
REQ-007 Ports reg_wr (output, 1 bit), reg_waddr (output, 5 bits) and reg_wdata (output, 8 bits) form a one-cycle write notification.
REQ-008 Ports rd_addr (input, 5 bits) and rd_data (output, 8 bits) form the FPGA-side read port.
REQ-009 Ports frame_done and frame_abort: outputs, 1 bit each, single-cycle status pulses.

Function
REQ-010 The protocol SHALL be MSB first, with one 8-bit instruction followed by N+1 data bytes.
- Instruction bit 7: R/W, 1 = read.
- Instruction bits 6:5: N.
- Instruction bits 4:0: start address.
REQ-011 The block SHALL sample spi_sdi on each synchronized spi_sclk rising edge while spi_csb is low, and drive spi_sdo on each synchronized falling edge.
- Supported spi_sclk frequency is at most clk/8.
REQ-012 The FSM SHALL have the states IDLE, INSTR, DATA and OVERRUN, with these transitions:
- IDLE -> INSTR on a spi_csb falling edge.
- INSTR -> DATA after 8 bits.
- DATA -> OVERRUN after byte N completes.
- Any state -> IDLE on a spi_csb rising edge.
REQ-013 For a write, after each complete data byte the block SHALL:
- update the register at the current address;
- pulse reg_wr for exactly 1 clk, with reg_waddr and reg_wdata valid in that cycle;
- do this no later than SYNC_STAGES+2 clk cycles after the spi_sclk rising edge that sampled the byte's last bit.
REQ-014 The data-byte address SHALL equal the start address plus the byte index, modulo 32, so address 0x1F wraps to 0x00.
REQ-015 For a read, the block SHALL load regfile[address] into the shift register when the instruction completes.
- The bit 7 value SHALL appear on the first spi_sclk falling edge after the 8th instruction bit.
- spi_sdo_oe SHALL be 1 only during the read data bytes.
REQ-016 In OVERRUN, extra bits SHALL be ignored, with no writes, spi_sdo_oe = 0 and spi_sdo = 1.
REQ-017 On a spi_csb rising edge after all N+1 bytes, the block SHALL pulse frame_done for 1 clk.
- If the rising edge comes earlier, it SHALL pulse frame_abort instead.
- Bytes already completed remain committed; a partial byte is discarded.
REQ-018 rd_data SHALL equal regfile[rd_addr], registered with 1 clk latency.
- If an SPI write and an FPGA read hit the same address in the same cycle, rd_data SHALL return the new value one cycle later.
REQ-019 A spi_csb falling edge outside IDLE (glitch) SHALL restart the frame in INSTR.

Reset
REQ-020 While rst = 1 the block SHALL hold the reset state, for both assertion mid-frame and assertion at power-up:
- all 32 registers = 8'h00, FSM = IDLE and the bit counter = 0;
- spi_sdo = 1 and spi_sdo_oe = 0;
- reg_wr = 0, reg_waddr = 0 and reg_wdata = 0;
- rd_data = 0, frame_done = 0 and frame_abort = 0;
- synchronizer flops preset so that spi_csb reads high and spi_sclk reads low.
REQ-021 After rst deasserts, the first frame SHALL begin on the next spi_csb falling edge. A frame in progress during reset produces no frame_abort.

Structure
REQ-022 A shared package SHALL hold:
- the FSM state enum;
- the field positions: RW_BIT = 7, N_MSB = 6, N_LSB = 5, ADDR_W = 5;
- REG_COUNT = 32;
- REG_RESET = 8'h00.
REQ-023 A sub-module spi_in_sync SHALL hold the SYNC_STAGES-deep synchronizer and the rise/fall edge detectors for spi_sclk and spi_csb.

Verification
REQ-024 Write frame 16'h0A0F -> reg_wr once with reg_waddr = 0x0A and reg_wdata = 0x0F; frame_done = 1; rd_addr = 0x0A gives rd_data = 0x0F.
REQ-025 Write the six frames 0004, 0100, 0501, 060F, 0900, 0A0F, each 16 bits with spi_csb high in between.
- Expected register contents: 00 = 04, 01 = 00, 05 = 01, 06 = 0F, 09 = 00, 0A = 0F.
- Expected pulse counts: 6 frame_done, 6 reg_wr.
REQ-026 Multi-byte write: instruction 0x45 followed by AA, BB, CC -> regs 05 = AA, 06 = BB, 07 = CC; then a second frame with instruction 0x3F followed by 11, 22 -> regs 1F = 11, 00 = 22 (wrap).
REQ-027 Read: after the REQ-024 write, frame 16'h8A00 -> spi_sdo shifts 0x0F MSB first, with spi_sdo_oe high for exactly 8 bits; no reg_wr.
REQ-028 Abort: 16'h0355 with spi_csb raised after 12 bits -> no reg_wr, frame_abort = 1, reg 03 unchanged. A 20-bit 16'h0455 frame -> reg 04 = 55, last 4 bits ignored, frame_done = 1.
REQ-029 Assert rst after bit 10 of a frame -> all registers 0 and spi_sdo_oe = 0. The next full 16'h0A0F frame writes correctly.
